// File: rtl/weight_row_sequencer_if.sv
// Handshake and BRAM pin bundle shared by the weight row sequencer and its environment.
// The slave modport is the sequencer's view; master is the requester/BRAM side.
interface weight_row_sequencer_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic          rd_start;
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          w_ready;
    logic          w_valid;
    logic [DW-1:0] w_data;
    logic [AW-1:0] w_idx;
    logic          w_last;
    logic          busy;
    logic          done;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_di;
    logic [DW-1:0] bram_do;

    modport slave (
        input  rd_start, ld_start, ld_valid, ld_data, w_ready, bram_do,
        output ld_ready, w_valid, w_data, w_idx, w_last, busy, done,
               bram_en, bram_we, bram_addr, bram_di
    );

    modport master (
        output rd_start, ld_start, ld_valid, ld_data, w_ready, bram_do,
        input  ld_ready, w_valid, w_data, w_idx, w_last, busy, done,
               bram_en, bram_we, bram_addr, bram_di
    );
endinterface

// File: rtl/weight_row_sequencer.sv
// Owns one weight-row BRAM: loads a full row from the host, or streams it to the MAC
// one word per cycle with backpressure. Load and read never overlap.
module weight_row_sequencer #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    weight_row_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, LOAD} state_e;

    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_P  = (AW+1)'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic          w_valid_q, w_valid_d;
    logic          w_last_q, w_last_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [AW-1:0] w_idx_q, w_idx_d;
    logic          issue;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            rptr_q    <= '0;
            wptr_q    <= '0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            w_data_q  <= '0;
            w_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            w_valid_q <= w_valid_d;
            w_last_q  <= w_last_d;
            w_data_q  <= w_data_d;
            w_idx_q   <= w_idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;
        w_valid_d     = w_valid_q;
        w_last_d      = w_last_q;
        w_data_d      = w_data_q;
        w_idx_d       = w_idx_q;
        issue         = 1'b0;
        bus.bram_en   = 1'b0;
        bus.bram_we   = 1'b0;
        bus.bram_addr = '0;
        bus.bram_di   = '0;
        bus.ld_ready  = 1'b0;
        bus.done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                end else if (bus.rd_start) begin
                    state_d = READ;
                    rptr_d  = '0;
                end
            end
            READ: begin
                // The BRAM updates DO on the negedge of the issue cycle, so it is
                // already valid when the output register captures it at the posedge.
                issue = (!w_valid_q || bus.w_ready) && (rptr_q < DEPTH_P);
                if (issue) begin
                    bus.bram_en   = 1'b1;
                    bus.bram_addr = rptr_q[AW-1:0];
                    rptr_d        = rptr_q + 1'b1;
                    w_data_d      = bus.bram_do;
                    w_idx_d       = rptr_q[AW-1:0];
                    w_valid_d     = 1'b1;
                    w_last_d      = (rptr_q == LAST_P);
                end else if (bus.w_ready) begin
                    w_valid_d = 1'b0;
                    w_last_d  = 1'b0;
                end
                if (w_valid_q && bus.w_ready && w_last_q) begin
                    bus.done = 1'b1;
                    state_d  = IDLE;
                end
            end
            LOAD: begin
                bus.ld_ready  = 1'b1;
                bus.bram_en   = bus.ld_valid;
                bus.bram_we   = bus.ld_valid;
                bus.bram_addr = wptr_q[AW-1:0];
                bus.bram_di   = bus.ld_data;
                if (bus.ld_valid) begin
                    wptr_d = wptr_q + 1'b1;
                    if (wptr_q == LAST_P) begin
                        bus.done = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.w_valid = w_valid_q;
    assign bus.w_last  = w_last_q;
    assign bus.w_data  = w_data_q;
    assign bus.w_idx   = w_idx_q;
endmodule

// File: tb/tb_weight_row_sequencer.sv
// Scoreboard bench for weight_row_sequencer with a behavioural BRAM and row model.
module tb_weight_row_sequencer;
    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    weight_row_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    weight_row_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Behavioural BRAM: negedge registered read-first
    logic [DW-1:0] mem [0:31];
    always @(negedge CLK) begin
        if (bus.bram_en && (int'(bus.bram_addr) < DEPTH)) begin
            if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_di;
            bus.bram_do <= mem[bus.bram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference row contents and scoreboard queues
    logic [DW-1:0] row [0:DEPTH-1];
    logic [DW-1:0] exp_data_q[$];
    int            exp_idx_q[$];
    int            mode = 0;          // 0 idle, 1 read, 2 load
    int            pop_total = 0;
    int            vcnt_total = 0;
    int            ld_total = 0;
    int            ld_base = 0;
    int            wr_mode = 0;       // 0 ready high, 1 pattern 1,0,0, 2 random

    // w_ready driver
    initial begin
        int ph;
        ph = 0;
        bus.w_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (wr_mode)
                1: begin bus.w_ready = (ph == 0); ph = (ph + 1) % 3; end
                2: bus.w_ready = 1'($urandom_range(0, 1));
                default: bus.w_ready = 1'b1;
            endcase
        end
    end

    // Monitor
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;
    always @(negedge CLK) begin
        logic exp_done;
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (bus.bram_en) chk_eq("addr_range", 32'(int'(bus.bram_addr) < DEPTH), 32'd1);
            if (bus.bram_we) chk_eq("we_only_in_load", 32'(bus.ld_ready), 32'd1);
            if (mode != 2) chk_eq("ld_ready_outside_load", 32'(bus.ld_ready), 32'd0);
            if (bus.ld_valid && bus.ld_ready) begin
                if (mode != 2) chk_eq("unexpected_load", 32'd1, 32'd0);
                exp_done = ((ld_total - ld_base) == DEPTH - 1);
                ld_total++;
            end
            if (bus.w_valid) vcnt_total++;
            if (bus.w_valid && bus.w_ready) begin
                if (exp_data_q.size() == 0) begin
                    chk_eq("unexpected_word", 32'(bus.w_idx), 32'hFFFF_FFFF);
                end else begin
                    logic [DW-1:0] ed;
                    int            ei;
                    ed = exp_data_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    chk_eq("w_data", 32'(bus.w_data), 32'(ed));
                    chk_eq("w_idx", 32'(bus.w_idx), 32'(ei));
                    chk_eq("w_last", 32'(bus.w_last), 32'(ei == DEPTH - 1));
                    exp_done = (ei == DEPTH - 1);
                    pop_total++;
                end
            end
            chk_eq("done", 32'(bus.done), 32'(exp_done));
            if (prev_stall) begin
                chk_eq("stall_hold_valid", 32'(bus.w_valid), 32'd1);
                chk_eq("stall_hold_data", 32'(bus.w_data), 32'(prev_data));
                chk_eq("stall_hold_idx", 32'(bus.w_idx), 32'(prev_idx));
            end
            if (bus.w_valid && !bus.w_ready) chk_eq("stall_bram_en", 32'(bus.bram_en), 32'd0);
            prev_stall = bus.w_valid && !bus.w_ready;
            prev_data  = bus.w_data;
            prev_idx   = bus.w_idx;
        end
    end

    task automatic do_load(input bit gaps, input bit rand_data, input bit poke_rd, input bit both);
        int  i, guard, rdy_cycles;
        bit  acc;
        i = 0; guard = 0; rdy_cycles = 0;
        mode = 2;
        ld_base = ld_total;
        bus.ld_start = 1'b1;
        bus.rd_start = both;
        @(posedge CLK); #1;
        bus.ld_start = 1'b0;
        bus.rd_start = 1'b0;
        chk_eq("ld_ready_after_start", 32'(bus.ld_ready), 32'd1);
        chk_eq("busy_in_load", 32'(bus.busy), 32'd1);
        while (i < DEPTH && guard < 2000) begin
            bus.ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.ld_data  = rand_data ? 16'($urandom) : 16'(16'h0100 + i);
            bus.rd_start = poke_rd && (guard == 7);
            @(negedge CLK);
            if (bus.ld_ready) rdy_cycles++;
            acc = bus.ld_valid && bus.ld_ready;
            @(posedge CLK); #1;
            if (acc) begin
                row[i] = bus.ld_data;
                i++;
            end
            guard++;
        end
        bus.ld_valid = 1'b0;
        bus.rd_start = 1'b0;
        chk_eq("load_words_accepted", 32'(i), 32'(DEPTH));
        chk_eq("busy_after_load", 32'(bus.busy), 32'd0);
        chk_eq("w_valid_after_load", 32'(bus.w_valid), 32'd0);
        if (!gaps) chk_eq("ld_ready_cycles", 32'(rdy_cycles), 32'(DEPTH));
        mode = 0;
        @(posedge CLK); #1;
    endtask

    task automatic do_read(input int wm, input bit poke_ld, input int rst_at);
        int guard, p0, v0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_data_q.push_back(row[k]);
            exp_idx_q.push_back(k);
        end
        wr_mode = wm;
        mode = 1;
        p0 = pop_total;
        v0 = vcnt_total;
        guard = 0;
        bus.rd_start = 1'b1;
        @(posedge CLK); #1;
        bus.rd_start = 1'b0;
        chk_eq("busy_in_read", 32'(bus.busy), 32'd1);
        while ((pop_total - p0) < DEPTH && guard < 1000) begin
            if (rst_at > 0 && (pop_total - p0) >= rst_at) break;
            bus.ld_start = poke_ld && (guard == 5);
            @(posedge CLK); #1;
            guard++;
        end
        bus.ld_start = 1'b0;
        if (rst_at > 0) begin
            RST = 1'b1;
            @(posedge CLK); #1;
            RST = 1'b0;
            exp_data_q.delete();
            exp_idx_q.delete();
            chk_eq("rst_w_valid", 32'(bus.w_valid), 32'd0);
            chk_eq("rst_busy", 32'(bus.busy), 32'd0);
        end else begin
            chk_eq("read_words", 32'(pop_total - p0), 32'(DEPTH));
            chk_eq("busy_after_read", 32'(bus.busy), 32'd0);
            if (wm == 0) chk_eq("w_valid_cycles", 32'(vcnt_total - v0), 32'(DEPTH));
        end
        mode = 0;
        wr_mode = 0;
        @(posedge CLK); #1;
    endtask

    initial begin
        bus.rd_start = 1'b0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.bram_do  = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk_eq("reset_outputs",
               {bus.w_valid, bus.w_last, bus.done, bus.busy, bus.ld_ready, bus.bram_en,
                bus.bram_we, 25'(bus.w_idx) | 25'(bus.bram_addr)},
               32'd0);
        chk_eq("reset_w_data", 32'(bus.w_data), 32'd0);
        chk_eq("reset_bram_di", 32'(bus.bram_di), 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        do_load(1'b0, 1'b0, 1'b0, 1'b0);   // 0x0100+i, ld_valid held
        do_read(0, 1'b0, 0);               // full-rate read
        do_read(1, 1'b0, 0);               // ready 1,0,0 pattern
        do_load(1'b1, 1'b1, 1'b1, 1'b0);   // random data/gaps, rd_start poked
        do_read(2, 1'b1, 0);               // random ready, ld_start poked
        do_load(1'b1, 1'b1, 1'b0, 1'b1);   // both starts together
        do_read(2, 1'b0, 0);
        do_read(0, 1'b0, 10);              // reset at 10th word
        do_read(2, 1'b0, 0);               // fresh full row after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
